// File: rtl/iobuf_stream_ctrl.sv
// Frame load/unload controller for the four-bank 64x64-bit FFT I/O buffer.
// Define IOBUF_LAST_EN to add the M_LAST end-of-frame marker output.
module iobuf_stream_ctrl #(
  parameter int unsigned N_ROWS = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START_LD,
  input  logic        START_UL,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic [63:0] S_DATA,
  output logic        M_VALID,
  input  logic        M_READY,
  output logic [63:0] M_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        WE,
  output logic [5:0]  ADDR0,
  output logic [5:0]  ADDR1,
  output logic [5:0]  ADDR2,
  output logic [5:0]  ADDR3,
  output logic [63:0] D0,
  output logic [63:0] D1,
  output logic [63:0] D2,
  output logic [63:0] D3,
  input  logic [63:0] Q0,
  input  logic [63:0] Q1,
  input  logic [63:0] Q2,
  input  logic [63:0] Q3
`ifdef IOBUF_LAST_EN
  ,
  output logic        M_LAST
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, UL_ADDR, UL_CAP, UL_SEND} state_t;

  localparam logic [5:0] LAST_ROW = 6'(N_ROWS - 1);

  state_t      state;
  logic [5:0]  row;
  logic [5:0]  addr;
  logic [1:0]  lane;
  logic        cap_wait;
  logic [63:0] gather [4];
  logic [63:0] outbuf [4];

  assign S_READY = (state == LOAD);
  assign BUSY    = (state != IDLE);
  assign ADDR0   = addr;
  assign ADDR1   = addr;
  assign ADDR2   = addr;
  assign ADDR3   = addr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      row      <= '0;
      addr     <= '0;
      lane     <= '0;
      cap_wait <= 1'b0;
      gather   <= '{default: '0};
      outbuf   <= '{default: '0};
      WE       <= 1'b0;
      DONE     <= 1'b0;
      D0       <= '0;
      D1       <= '0;
      D2       <= '0;
      D3       <= '0;
      M_VALID  <= 1'b0;
      M_DATA   <= '0;
`ifdef IOBUF_LAST_EN
      M_LAST   <= 1'b0;
`endif
    end else begin
      WE   <= 1'b0;
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START_LD) begin
            state <= LOAD;
            row   <= '0;
            lane  <= '0;
          end else if (START_UL) begin
            state <= UL_ADDR;
            row   <= '0;
            lane  <= '0;
          end
        end
        LOAD: begin
          // S_READY is high throughout LOAD, so S_VALID alone marks an accept.
          if (S_VALID) begin
            if (lane != 2'd3) begin
              gather[lane] <= S_DATA;
              lane         <= lane + 2'd1;
            end else begin
              WE   <= 1'b1;
              addr <= row;
              D0   <= gather[0];
              D1   <= gather[1];
              D2   <= gather[2];
              D3   <= S_DATA;
              lane <= '0;
              if (row == LAST_ROW) begin
                state <= IDLE;
                DONE  <= 1'b1;
                row   <= '0;
              end else begin
                row <= row + 6'd1;
              end
            end
          end
        end
        UL_ADDR: begin
          addr     <= row;
          cap_wait <= 1'b0;
          state    <= UL_CAP;
        end
        UL_CAP: begin
          // First cycle lets the buffer register the address; Q is valid in the second.
          if (!cap_wait) begin
            cap_wait <= 1'b1;
          end else begin
            outbuf[0] <= Q0;
            outbuf[1] <= Q1;
            outbuf[2] <= Q2;
            outbuf[3] <= Q3;
            M_DATA    <= Q0;
            M_VALID   <= 1'b1;
            lane      <= '0;
            state     <= UL_SEND;
`ifdef IOBUF_LAST_EN
            M_LAST    <= 1'b0;
`endif
          end
        end
        UL_SEND: begin
          if (M_READY) begin
            if (lane != 2'd3) begin
              lane   <= lane + 2'd1;
              M_DATA <= outbuf[lane + 2'd1];
`ifdef IOBUF_LAST_EN
              M_LAST <= (row == LAST_ROW) && (lane == 2'd2);
`endif
            end else begin
              M_VALID <= 1'b0;
              lane    <= '0;
`ifdef IOBUF_LAST_EN
              M_LAST  <= 1'b0;
`endif
              if (row == LAST_ROW) begin
                state <= IDLE;
                DONE  <= 1'b1;
                row   <= '0;
              end else begin
                row   <= row + 6'd1;
                state <= UL_ADDR;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iobuf_stream_ctrl.sv
// Scoreboard bench for iobuf_stream_ctrl: a 64-row instance and a 1-row instance,
// each attached to a behavioural model of the four-bank registered-read buffer.
module tb_iobuf_stream_ctrl;

  typedef struct {
    logic [5:0]  a;
    logic [63:0] d0, d1, d2, d3;
    bit          last;
  } wr_t;

  typedef struct {
    logic [63:0] d;
    bit          last;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_ld, start_ul, s_valid, m_ready;
  logic        s_ready, m_valid, busy, done, we;
  logic [63:0] s_data, m_data, d0, d1, d2, d3;
  logic [5:0]  addr0, addr1, addr2, addr3;
  logic [63:0] mem_a [4][64];
  logic [63:0] q_a [4];

  logic        start_ld_b, start_ul_b, s_valid_b, m_ready_b;
  logic        s_ready_b, m_valid_b, busy_b, done_b, we_b;
  logic [63:0] s_data_b, m_data_b, d0_b, d1_b, d2_b, d3_b;
  logic [5:0]  addr0_b, addr1_b, addr2_b, addr3_b;
  logic [63:0] mem_b [4][64];
  logic [63:0] q_b [4];

`ifdef IOBUF_LAST_EN
  logic m_last, m_last_b;
`endif

  iobuf_stream_ctrl #(.N_ROWS(64)) dut (
    .CLK(clk), .RST(rst), .START_LD(start_ld), .START_UL(start_ul),
    .S_VALID(s_valid), .S_READY(s_ready), .S_DATA(s_data),
    .M_VALID(m_valid), .M_READY(m_ready), .M_DATA(m_data),
    .BUSY(busy), .DONE(done), .WE(we),
    .ADDR0(addr0), .ADDR1(addr1), .ADDR2(addr2), .ADDR3(addr3),
    .D0(d0), .D1(d1), .D2(d2), .D3(d3),
    .Q0(q_a[0]), .Q1(q_a[1]), .Q2(q_a[2]), .Q3(q_a[3])
`ifdef IOBUF_LAST_EN
    , .M_LAST(m_last)
`endif
  );

  iobuf_stream_ctrl #(.N_ROWS(1)) dut_b (
    .CLK(clk), .RST(rst), .START_LD(start_ld_b), .START_UL(start_ul_b),
    .S_VALID(s_valid_b), .S_READY(s_ready_b), .S_DATA(s_data_b),
    .M_VALID(m_valid_b), .M_READY(m_ready_b), .M_DATA(m_data_b),
    .BUSY(busy_b), .DONE(done_b), .WE(we_b),
    .ADDR0(addr0_b), .ADDR1(addr1_b), .ADDR2(addr2_b), .ADDR3(addr3_b),
    .D0(d0_b), .D1(d1_b), .D2(d2_b), .D3(d3_b),
    .Q0(q_b[0]), .Q1(q_b[1]), .Q2(q_b[2]), .Q3(q_b[3])
`ifdef IOBUF_LAST_EN
    , .M_LAST(m_last_b)
`endif
  );

  // Buffer models: write on WE, otherwise registered read of the addressed row.
  always @(posedge clk) begin
    if (we) begin
      mem_a[0][addr0] <= d0; mem_a[1][addr1] <= d1;
      mem_a[2][addr2] <= d2; mem_a[3][addr3] <= d3;
    end else begin
      q_a[0] <= mem_a[0][addr0]; q_a[1] <= mem_a[1][addr1];
      q_a[2] <= mem_a[2][addr2]; q_a[3] <= mem_a[3][addr3];
    end
    if (we_b) begin
      mem_b[0][addr0_b] <= d0_b; mem_b[1][addr1_b] <= d1_b;
      mem_b[2][addr2_b] <= d2_b; mem_b[3][addr3_b] <= d3_b;
    end else begin
      q_b[0] <= mem_b[0][addr0_b]; q_b[1] <= mem_b[1][addr1_b];
      q_b[2] <= mem_b[2][addr2_b]; q_b[3] <= mem_b[3][addr3_b];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  wr_t  wq_a[$], wq_b[$];
  out_t mq_a[$], mq_b[$];
  wr_t  ea, eb;
  out_t oa, ob;
  int   cyc = 0, last_hs = -100, rdy_cnt = 0;
  int   we_b_cnt = 0, done_b_cnt = 0, out_b_cnt = 0;
  bit   prev_we = 0, prev_stall = 0;
  logic [63:0] prev_md;

  // Monitor for the 64-row instance.
  always @(negedge clk) begin
    cyc++;
    if (s_ready === 1'b1) rdy_cnt++;
    if (we === 1'b1) begin
      chk("we_single_cycle", 64'(prev_we), 0);
      if (wq_a.size() == 0) chk("unexpected_we", 1, 0);
      else begin
        ea = wq_a.pop_front();
        chk("wr_addr0", addr0, ea.a);
        chk("wr_addr1", addr1, ea.a);
        chk("wr_addr2", addr2, ea.a);
        chk("wr_addr3", addr3, ea.a);
        chk("wr_d0", d0, ea.d0);
        chk("wr_d1", d1, ea.d1);
        chk("wr_d2", d2, ea.d2);
        chk("wr_d3", d3, ea.d3);
        chk("done_with_last_we", done, 64'(ea.last));
      end
    end else if (done === 1'b1) begin
      chk("ul_done_after_last", 64'(cyc - last_hs), 1);
    end
    if (prev_stall) begin
      chk("stall_valid_held", m_valid, 1);
      chk("stall_data_held", m_data, prev_md);
    end
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      if (mq_a.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        oa = mq_a.pop_front();
        chk("m_data", m_data, oa.d);
`ifdef IOBUF_LAST_EN
        chk("m_last", m_last, 64'(oa.last));
`endif
        if (oa.last) last_hs = cyc;
      end
    end
    prev_we    = (we === 1'b1);
    prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
    prev_md    = m_data;
  end

  // Monitor for the 1-row instance.
  always @(negedge clk) begin
    if (we_b === 1'b1) begin
      we_b_cnt++;
      if (wq_b.size() == 0) chk("b_unexpected_we", 1, 0);
      else begin
        eb = wq_b.pop_front();
        chk("b_wr_addr", addr0_b, eb.a);
        chk("b_wr_d0", d0_b, eb.d0);
        chk("b_wr_d3", d3_b, eb.d3);
        chk("b_done_with_we", done_b, 64'(eb.last));
      end
    end
    if (done_b === 1'b1) done_b_cnt++;
    if (m_valid_b === 1'b1 && m_ready_b === 1'b1) begin
      out_b_cnt++;
      if (mq_b.size() == 0) chk("b_unexpected_out", 1, 0);
      else begin
        ob = mq_b.pop_front();
        chk("b_m_data", m_data_b, ob.d);
`ifdef IOBUF_LAST_EN
        chk("b_m_last", m_last_b, 64'(ob.last));
`endif
      end
    end
  end

  bit tog = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk); #1;
      if (tog) begin
        m_ready = pat[k];
        k = (k + 1) % 4;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic load_a(input logic [63:0] base, input int n, input int fs, input int ul_at);
    int g;
    for (int i = 0; i < n; i++) begin
      s_data   = base + 64'(i);
      s_valid  = 1'b1;
      start_ul = (i == ul_at);
      g = 0;
      while (s_ready !== 1'b1 && g < 50) begin
        @(posedge clk); #1;
        g++;
      end
      if (g >= 50) begin
        chk("s_ready_timeout", 0, 1);
        s_valid = 1'b0;
        return;
      end
      if (i % 4 == 3)
        wq_a.push_back('{a: 6'(i / 4), d0: base + 64'(i - 3), d1: base + 64'(i - 2),
                         d2: base + 64'(i - 1), d3: base + 64'(i), last: (i == fs - 1)});
      if (i == ul_at + 1) begin
        chk("ul_ignored_sready", s_ready, 1);
        chk("ul_ignored_mvalid", m_valid, 0);
      end
      @(posedge clk); #1;
    end
    s_valid  = 1'b0;
    start_ul = 1'b0;
  endtask

  task automatic unload_a(input bit timed);
    int n;
    for (int i = 0; i < 256; i++) mq_a.push_back('{d: 64'(i), last: (i == 255)});
    start_ul = 1'b1;
    @(posedge clk); #1;
    start_ul = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 5000);
    chk("ul_done_seen", done, 1);
    if (timed) chk("ul_cycle_count", 64'(n), 449);
    @(posedge clk); #1;
    chk("ul_all_samples_out", 64'(mq_a.size()), 0);
    chk("ul_idle_after", busy, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start_ld = 1'b0; start_ul = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    start_ld_b = 1'b0; start_ul_b = 1'b0; s_valid_b = 1'b0; s_data_b = '0; m_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", we, 0);
    chk("rst_addr0", addr0, 0);
    chk("rst_addr3", addr3, 0);
    chk("rst_d0", d0, 0);
    chk("rst_d3", d3, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_b_busy", busy_b, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Both starts together: load must win, no read issued.
    rdy_cnt  = 0;
    start_ld = 1'b1;
    start_ul = 1'b1;
    @(posedge clk); #1;
    start_ld = 1'b0;
    start_ul = 1'b0;
    chk("dual_start_sready", s_ready, 1);
    chk("dual_start_mvalid", m_valid, 0);
    load_a(64'h0, 256, 256, 20);
    repeat (4) @(posedge clk);
    #1;
    chk("load_sready_cycles", 64'(rdy_cnt), 256);
    chk("load_all_rows_written", 64'(wq_a.size()), 0);
    chk("load_idle_after", busy, 0);

    unload_a(1'b1);

    tog = 1'b1;
    unload_a(1'b0);
    tog = 1'b0;
    m_ready = 1'b1;

    // Reset after 10 samples of a load: rows 0-1 written, partial row dropped.
    start_ld = 1'b1;
    @(posedge clk); #1;
    start_ld = 1'b0;
    load_a(64'h1000, 10, 256, -5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_we", we, 0);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_addr0", addr0, 0);
    chk("midrst_d0", d0, 0);
    chk("midrst_d3", d3, 0);
    chk("midrst_rows_written", 64'(wq_a.size()), 0);

    start_ld = 1'b1;
    @(posedge clk); #1;
    start_ld = 1'b0;
    load_a(64'h2000, 256, 256, -5);
    repeat (4) @(posedge clk);
    #1;
    chk("reload_all_rows_written", 64'(wq_a.size()), 0);
    chk("reload_idle_after", busy, 0);

    // Single-row instance: one write, four outputs, two DONE pulses.
    start_ld_b = 1'b1;
    @(posedge clk); #1;
    start_ld_b = 1'b0;
    chk("b_sready", s_ready_b, 1);
    for (int i = 0; i < 4; i++) begin
      s_data_b  = 64'hA0 + 64'(i);
      s_valid_b = 1'b1;
      if (i == 3)
        wq_b.push_back('{a: 6'd0, d0: 64'hA0, d1: 64'hA1, d2: 64'hA2, d3: 64'hA3, last: 1'b1});
      @(posedge clk); #1;
    end
    s_valid_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("b_load_idle", busy_b, 0);
    for (int i = 0; i < 4; i++) mq_b.push_back('{d: 64'hA0 + 64'(i), last: (i == 3)});
    start_ul_b = 1'b1;
    @(posedge clk); #1;
    start_ul_b = 1'b0;
    n = 0;
    while (done_b_cnt < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b_we_count", 64'(we_b_cnt), 1);
    chk("b_done_count", 64'(done_b_cnt), 2);
    chk("b_out_count", 64'(out_b_cnt), 4);
    chk("b_out_queue_empty", 64'(mq_b.size()), 0);
    chk("b_idle_after", busy_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
